power_sequencer_pio: RTL and testbench



---
 rtl/power_sequencer_pio.sv | 195 +++++++++++++++++++
 tb/tb_power_sequencer_pio.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer_pio.sv
// Avalon-MM power-rail enable port: direct/SET/CLR writes plus a hardware
// sequencer that walks out_port to a target mask (on ascending, off descending).
`timescale 1ns/1ps

module power_sequencer_pio #(
  parameter int                NUM_CH      = 8,
  parameter logic [NUM_CH-1:0] RESET_VALUE = {NUM_CH{1'b1}},
  parameter int                DELAY_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] out_port,
  output logic              busy,
  output logic              irq
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_UP_WAIT,
    S_DOWN,
    S_DOWN_WAIT
  } state_t;

  state_t              state_reg,  state_next;
  logic [IDX_W-1:0]    idx_reg,    idx_next;
  logic [DELAY_W-1:0]  cnt_reg,    cnt_next;
  logic [NUM_CH-1:0]   out_reg,    out_next;
  logic [NUM_CH-1:0]   target_reg, target_next;
  logic [DELAY_W-1:0]  delay_reg,  delay_next;
  logic                done_reg,   done_next;

  logic reg_wr;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic cur_target;
  logic cur_out;
  logic step_done;
  logic unused_wd;

  assign reg_wr    = chipselect & ~write_n;
  assign ctrl_wr   = reg_wr & (address == 3'd5);
  assign busy      = (state_reg != S_IDLE);
  assign start_req = ctrl_wr & writedata[0] & ~writedata[1] & ~busy;
  assign abort_req = ctrl_wr & writedata[1] & busy;
  assign unused_wd = ^writedata;

  assign out_port = out_reg;
  assign irq      = done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      out_reg    <= RESET_VALUE;
      target_reg <= '0;
      delay_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      out_reg    <= out_next;
      target_reg <= target_next;
      delay_reg  <= delay_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    out_next    = out_reg;
    target_next = target_reg;
    delay_next  = delay_reg;
    done_next   = done_reg;
    step_done   = 1'b0;
    cur_target  = target_reg[idx_reg];
    cur_out     = out_reg[idx_reg];

    // Software register writes; direct output writes are locked out while walking.
    if (reg_wr) begin
      case (address)
        3'd0: if (!busy) out_next = writedata[NUM_CH-1:0];
        3'd1: if (!busy) out_next = out_reg | writedata[NUM_CH-1:0];
        3'd2: if (!busy) out_next = out_reg & ~writedata[NUM_CH-1:0];
        3'd3: target_next = writedata[NUM_CH-1:0];
        3'd4: delay_next  = writedata[DELAY_W-1:0];
        3'd5: if (writedata[2]) done_next = 1'b0;
        default: ;
      endcase
    end

    case (state_reg)
      S_IDLE: begin
        if (start_req) begin
          state_next = S_UP;
          idx_next   = '0;
          done_next  = 1'b0;
        end
      end

      S_UP, S_UP_WAIT: begin
        if (state_reg == S_UP) begin
          if (cur_target && !cur_out) begin
            out_next[idx_reg] = 1'b1;
            cnt_next          = delay_reg;
            state_next        = S_UP_WAIT;
          end else begin
            step_done = 1'b1;
          end
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          step_done = 1'b1;
        end

        // The down walk starts from the top channel, so idx stays put on the turn.
        if (step_done) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_DOWN;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            state_next = S_UP;
          end
        end
      end

      S_DOWN, S_DOWN_WAIT: begin
        if (state_reg == S_DOWN) begin
          if (!cur_target && cur_out) begin
            out_next[idx_reg] = 1'b0;
            cnt_next          = delay_reg;
            state_next        = S_DOWN_WAIT;
          end else begin
            step_done = 1'b1;
          end
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          step_done = 1'b1;
        end

        // Completion sets done after any clear-done write above, so set wins.
        if (step_done) begin
          if (idx_reg == '0) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx_reg - IDX_ONE;
            state_next = S_DOWN;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Abort freezes the rails where they are and does not report completion.
    if (abort_req) begin
      state_next = S_IDLE;
      out_next   = out_reg;
      done_next  = writedata[2] ? 1'b0 : done_reg;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0, 3'd1, 3'd2: readdata[NUM_CH-1:0] = out_reg;
      3'd3:             readdata[NUM_CH-1:0] = target_reg;
      3'd4:             readdata[DELAY_W-1:0] = delay_reg;
      3'd5: begin
        readdata[0]          = busy;
        readdata[1]          = done_reg;
        readdata[8 +: IDX_W] = idx_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_power_sequencer_pio.sv
// Bench for power_sequencer_pio: event-schedule model of the rail walk,
// per-cycle output comparison, plus directed literal checks.
`timescale 1ns/1ps

module tb_power_sequencer_pio;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [N-1:0]  out_port;
  logic          busy;
  logic          irq;

  power_sequencer_pio #(.NUM_CH(N), .RESET_VALUE({N{1'b1}}), .DELAY_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_OUT, EV_BUSY0, EV_BUSY1, EV_DCLR, EV_DSET} ev_kind_t;
  typedef struct {
    int           cyc;
    ev_kind_t     kind;
    logic [N-1:0] val;
  } ev_t;

  ev_t          evq[$];
  logic [N-1:0] m_out;
  logic [N-1:0] m_target;
  int           m_delay;
  bit           m_busy;
  bit           m_done;

  int edge_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic void push(input int c, input ev_kind_t k, input logic [N-1:0] v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    evq.push_back(e);
  endfunction

  function automatic void model_reset();
    evq.delete();
    m_out    = '1;
    m_target = '0;
    m_delay  = 0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
  endfunction

  // Each evaluated channel costs 1 cycle if skipped, delay+2 if it toggles.
  function automatic void plan_sequence(input int s);
    logic [N-1:0] o;
    int t;
    o = m_out;
    t = s + 1;
    push(s, EV_BUSY1, '0);
    push(s, EV_DCLR, '0);
    for (int i = 0; i < N; i++) begin
      if (m_target[i] && !o[i]) begin
        o[i] = 1'b1;
        push(t, EV_OUT, o);
        t += m_delay + 2;
      end else begin
        t += 1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!m_target[i] && o[i]) begin
        o[i] = 1'b0;
        push(t, EV_OUT, o);
        t += m_delay + 2;
      end else begin
        t += 1;
      end
    end
    push(t - 1, EV_BUSY0, '0);
    push(t - 1, EV_DSET, '0);
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d, input int e);
    ev_t keep[$];
    case (a)
      3'd0: if (!m_busy) push(e, EV_OUT, d[N-1:0]);
      3'd1: if (!m_busy) push(e, EV_OUT, m_out | d[N-1:0]);
      3'd2: if (!m_busy) push(e, EV_OUT, m_out & ~d[N-1:0]);
      3'd3: m_target = d[N-1:0];
      3'd4: m_delay = int'(d[15:0]);
      3'd5: begin
        if (d[1] && m_busy) begin
          foreach (evq[i]) if (evq[i].cyc < e) keep.push_back(evq[i]);
          evq = keep;
          push(e, EV_BUSY0, '0);
        end else if (d[0] && !d[1] && !m_busy) begin
          plan_sequence(e);
        end
        if (d[2]) push(e, EV_DCLR, '0);
      end
      default: ;
    endcase
  endfunction

  function automatic void apply(input int c);
    ev_t keep[$];
    foreach (evq[i]) begin
      if (evq[i].cyc == c) begin
        case (evq[i].kind)
          EV_OUT:   m_out = evq[i].val;
          EV_BUSY0: m_busy = 1'b0;
          EV_BUSY1: m_busy = 1'b1;
          EV_DCLR:  m_done = 1'b0;
          default:  ;
        endcase
      end
    end
    foreach (evq[i]) if (evq[i].cyc == c && evq[i].kind == EV_DSET) m_done = 1'b1;
    foreach (evq[i]) if (evq[i].cyc > c) keep.push_back(evq[i]);
    evq = keep;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (!reset) begin
        apply(edge_cnt);
        chk("out_port", 32'(out_port), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("irq", 32'(irq), 32'(m_done));
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    e = edge_cnt + 1;
    model_write(a, d, e);
    $display("write addr=%0d data=%h at edge %0d", a, d, e);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a;
    #1;
    $display("read addr=%0d data=%h", a, readdata);
    chk(name, readdata, exp);
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, s;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_out", 32'(out_port), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(3'd5, 32'h0, "rst_status");
    rd(3'd3, 32'h0, "rst_target");
    rd(3'd4, 32'h0, "rst_delay");
    rd(3'd6, 32'h0, "addr6");

    // DATA / SET / CLR
    wr(3'd0, 32'h0F, e);
    rd(3'd0, 32'h0F, "data_wr");
    wr(3'd1, 32'h30, e);
    rd(3'd1, 32'h3F, "set_wr");
    wr(3'd2, 32'h03, e);
    rd(3'd2, 32'h3C, "clr_wr");

    // Up sequence: target 0x05, delay 3
    wr(3'd0, 32'h00, e);
    wr(3'd3, 32'h05, e);
    wr(3'd4, 32'h03, e);
    wr(3'd5, 32'h01, s);
    wait_edge(s + 1);
    chk("up_bit0", 32'(out_port), 32'h01);
    wait_edge(s + 6);
    chk("up_pre_bit2", 32'(out_port), 32'h01);
    wait_edge(s + 7);
    chk("up_bit2", 32'(out_port), 32'h05);
    wait_edge(s + 23);
    chk("up_busy_late", 32'(busy), 32'h1);
    wait_edge(s + 24);
    chk("up_done_busy", 32'(busy), 32'h0);
    chk("up_done_irq", 32'(irq), 32'h1);
    rd(3'd5, 32'h2, "up_status");
    rd(3'd3, 32'h5, "up_target");
    rd(3'd4, 32'h3, "up_delay");

    // Mixed sequence: out 0x81, target 0x03, delay 0
    wr(3'd0, 32'h81, e);
    wr(3'd3, 32'h03, e);
    wr(3'd4, 32'h00, e);
    wr(3'd5, 32'h01, s);
    wait_edge(s + 2);
    chk("mix_bit1", 32'(out_port), 32'h83);
    wait_edge(s + 5);
    wr(3'd0, 32'hAA, e);
    wait_edge(s + 10);
    chk("mix_clear7", 32'(out_port), 32'h03);
    chk("mix_busy", 32'(busy), 32'h1);
    wait_edge(s + 18);
    chk("mix_done", 32'(irq), 32'h1);
    chk("mix_idle", 32'(busy), 32'h0);
    rd(3'd0, 32'h03, "mix_final");

    // Abort during UP_WAIT
    wr(3'd0, 32'h00, e);
    wr(3'd3, 32'h0F, e);
    wr(3'd4, 32'd100, e);
    wr(3'd5, 32'h01, s);
    wait_edge(s + 50);
    wr(3'd5, 32'h02, e);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_out", 32'(out_port), 32'h01);
    chk("abort_irq", 32'(irq), 32'h0);
    wr(3'd5, 32'h03, e);
    repeat (3) @(negedge clk);
    chk("start_abort_idle", 32'(busy), 32'h0);

    // Done handling
    wr(3'd0, 32'h01, e);
    wr(3'd3, 32'h01, e);
    wr(3'd4, 32'h00, e);
    wr(3'd5, 32'h01, s);
    wait_idle(100);
    chk("done_set", 32'(irq), 32'h1);
    wr(3'd5, 32'h01, s);
    chk("start_clears_done", 32'(irq), 32'h0);
    wait_edge(s + 14);
    wr(3'd5, 32'h04, e);
    chk("clr_collide_edge", 32'(e), 32'(s + 16));
    chk("set_beats_clear", 32'(irq), 32'h1);
    wr(3'd5, 32'h04, e);
    chk("done_cleared", 32'(irq), 32'h0);

    // Asynchronous reset mid-sequence
    wr(3'd0, 32'h00, e);
    wr(3'd3, 32'hFF, e);
    wr(3'd4, 32'h05, e);
    wr(3'd5, 32'h01, s);
    wait_edge(s + 10);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_out", 32'(out_port), 32'hFF);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd3, 32'h0, "midrst_target");
    rd(3'd5, 32'h0, "midrst_status");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
